// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// alignment check applied when a request is accepted.
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_W   = 2'b10;
    localparam logic [1:0] SZ_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Misaligned half/word accesses and the reserved size never reach memory.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_B:    access_err = 1'b0;
            SZ_H:    access_err = addr_lo[0];
            SZ_W:    access_err = |addr_lo;
            default: access_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select plus sign/zero extension for loads.
// Purely combinational, zero latency; no flow control of its own.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Narrow stores are replicated on every lane so memory only needs the byte enables.
    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        case (size)
            SZ_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << addr_lo;
            end
            SZ_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = 4'b0011 << {addr_lo[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = ld_raw[7:0];
        case (addr_lo)
            2'd0: ld_byte = ld_raw[7:0];
            2'd1: ld_byte = ld_raw[15:8];
            2'd2: ld_byte = ld_raw[23:16];
            2'd3: ld_byte = ld_raw[31:24];
            default: ;
        endcase
        ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
        case (size)
            SZ_B:    ld_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: loads take >=3 cycles to rsp_valid, stores >=2, errors 1.
// Backpressure: stall holds the pipeline while a request is pending, gnt/rvalid pace it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [4:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] ld_ext;

    lsu_align u_align (
        .size        (size_q),
        .addr_lo     (addr_q[1:0]),
        .is_unsigned (uns_q),
        .st_data     (wdata_q),
        .st_wdata    (mem_wdata),
        .st_be       (mem_be),
        .ld_raw      (mem_rdata),
        .ld_data     (ld_ext)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    err_d   = access_err(req_size, req_addr[1:0]);
                    // Cleared here so stores and errors respond with zero data.
                    rdata_d = '0;
                    state_d = access_err(req_size, req_addr[1:0]) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) state_d = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Gated by reset so an asserted reset releases the pipeline in the same cycle.
    assign stall     = reset && ((state_q == IDLE && req_valid) || state_q == REQ || state_q == WAIT);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = (state_q == RESP) && err_q;
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_rd    = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a spec-level response/memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        stall, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [4:0]  rd;
    } exp_t;
    exp_t exp_q[$];
    exp_t cur_x;

    logic        mem_exp_on = 1'b0;
    logic        ex_we;
    logic [31:0] ex_addr, ex_wd;
    logic [3:0]  ex_be;

    logic [31:0] r_rdata, r_addr, r_wd;
    logic [3:0]  r_be;
    logic        r_err;
    int          r_lat;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a % 2 != 0) || (sz == 2'b10 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v;
        if (sz == 2'b00)      v = 32'd1 << (a % 4);
        else if (sz == 2'b01) v = 32'd3 << ((a % 4) - (a % 2));
        else                  v = 32'd15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'b00) return 32'h01010101 * (wd % 256);
        if (sz == 2'b01) return 32'h00010001 * (wd % 65536);
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] sh, v;
        int nb;
        if (sz == 2'b10) return raw;
        nb = (sz == 2'b00) ? 8 : 16;
        sh = raw >> (8 * (a % 4));
        v  = sh % (32'd1 << nb);
        if (!uns && v >= (32'd1 << (nb - 1))) v = v - (32'd1 << nb);
        return v;
    endfunction

    // Called at posedge+1 of an IDLE cycle; runs one transaction to its response.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input int g, input int rv, input logic [31:0] raw,
                       input logic poke, input logic noise);
        logic e;
        int   L;
        exp_t x;
        e = m_err(sz, addr);
        L = e ? 1 : (we ? 2 + g : 3 + g + rv);
        x.rdata = (e || we) ? 32'h0 : m_load(sz, uns, addr, raw);
        x.err   = e;
        x.rd    = rd;
        exp_q.push_back(x);
        ex_we = we; ex_addr = addr - (addr % 4); ex_be = m_be(sz, addr); ex_wd = m_wd(sz, wd);
        mem_exp_on = !e;
        r_lat = -1; r_rdata = 0; r_err = 0; r_addr = 0; r_be = 0; r_wd = 0;
        for (int c = 0; c <= L; c++) begin
            req_valid = (c == 0) || (poke && c == L);
            if (c == 0) begin
                req_we = we; req_size = sz; req_unsigned = uns;
                req_addr = addr; req_wdata = wd; req_rd = rd;
            end else if (poke && c == L) begin
                req_size = 2'b11; req_rd = 5'd31;
            end
            mem_gnt    = !e && ((c == 1 + g) || (noise && !we && c >= 2 + g && c < 2 + g + rv));
            mem_rvalid = !e && ((!we && c == 2 + g + rv) || (noise && c >= 1 && c < 1 + g));
            mem_rdata  = (c == 2 + g + rv) ? raw : (32'h5A5A0F0F ^ 32'(c));
            #3;
            check("stall", {31'b0, stall}, {31'b0, (c < L)});
            if (rsp_valid && r_lat < 0) begin
                r_lat = c; r_rdata = rsp_rdata; r_err = rsp_err;
            end
            if (mem_req) begin
                r_addr = mem_addr; r_be = mem_be; r_wd = mem_wdata;
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_exp_on = 1'b0;
        check("latency", r_lat, L);
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_rsp: rsp_valid=1 rd=%0d, expected no response", rsp_rd);
            end else begin
                cur_x = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, cur_x.rdata);
                check("rsp_err", {31'b0, rsp_err}, {31'b0, cur_x.err});
                check("rsp_rd", {27'b0, rsp_rd}, {27'b0, cur_x.rd});
            end
        end else begin
            check("quiet_rdata", rsp_rdata, 32'h0);
            check("quiet_err", {31'b0, rsp_err}, 32'h0);
        end
        if (mem_req) begin
            if (!mem_exp_on) begin
                checks++; errors++;
                $display("FAIL spurious_mem_req: mem_req=1 addr=%h, expected no access", mem_addr);
            end else begin
                check("mem_addr", mem_addr, ex_addr);
                check("mem_we", {31'b0, mem_we}, {31'b0, ex_we});
                if (ex_we) begin
                    check("mem_be", {28'b0, mem_be}, {28'b0, ex_be});
                    check("mem_wdata", mem_wdata, ex_wd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0; req_rd = 5'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_mem_req", {31'b0, mem_req}, 32'h0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 5'd5, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        check("t_word_ld_rdata", r_rdata, 32'hDEADBEEF);
        check("t_word_ld_lat", r_lat, 3);

        txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd6, 0, 0, 32'h80000000, 1'b0, 1'b0);
        check("t_sbyte_rdata", r_rdata, 32'hFFFFFF80);
        txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd7, 0, 0, 32'h80000000, 1'b0, 1'b0);
        check("t_ubyte_rdata", r_rdata, 32'h00000080);

        txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 5'd8, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t_hstore_addr", r_addr, 32'h200);
        check("t_hstore_be", {28'b0, r_be}, 32'hC);
        check("t_hstore_wd", r_wd, 32'hABCDABCD);
        check("t_hstore_lat", r_lat, 2);

        txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 5'd9, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t_misal_err", {31'b0, r_err}, 32'h1);
        check("t_misal_rdata", r_rdata, 32'h0);
        check("t_misal_lat", r_lat, 1);

        txn(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 5'd10, 4, 0, 32'h0, 1'b0, 1'b1);
        check("t_gnt_wait_lat", r_lat, 6);
        check("t_gnt_wait_wd", r_wd, 32'hCAFEF00D);

        txn(1'b0, 2'b01, 1'b0, 32'h206, 32'h0, 5'd11, 1, 2, 32'h80017FFF, 1'b0, 1'b1);
        check("t_shalf_rdata", r_rdata, 32'hFFFF8001);
        check("t_shalf_lat", r_lat, 6);

        txn(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 5'd12, 0, 0, 32'h1234F00D, 1'b1, 1'b0);
        check("t_uhalf_rdata", r_rdata, 32'h0000F00D);

        txn(1'b1, 2'b00, 1'b0, 32'h401, 32'h000000A5, 5'd13, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t_bstore_be", {28'b0, r_be}, 32'h2);
        check("t_bstore_wd", r_wd, 32'hA5A5A5A5);
        check("t_bstore_addr", r_addr, 32'h400);

        txn(1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 5'd14, 0, 0, 32'h0, 1'b1, 1'b0);
        check("t_rsv_err", {31'b0, r_err}, 32'h1);
        txn(1'b0, 2'b01, 1'b0, 32'h203, 32'h0, 5'd15, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t_hmisal_err", {31'b0, r_err}, 32'h1);
        txn(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 5'd16, 0, 0, 32'h0, 1'b0, 1'b0);
        check("t_st_rsv_rdata", r_rdata, 32'h0);

        // Reset pulsed in WAIT: transaction is dropped, a late rvalid must not respond.
        ex_we = 1'b0; ex_addr = 32'h500; ex_be = 4'hF; ex_wd = 32'h0; mem_exp_on = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h500; req_rd = 5'd17;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; reset = 1'b0; mem_exp_on = 1'b0;
        #3;
        check("rstw_stall", {31'b0, stall}, 32'h0);
        check("rstw_mem_req", {31'b0, mem_req}, 32'h0);
        check("rstw_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rstw_rsp_rd", {27'b0, rsp_rd}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        #3;
        check("late_rv_stall", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        #3;
        check("late_rv_no_rsp", {31'b0, rsp_valid}, 32'h0);
        @(posedge clk); #1;

        txn(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 5'd18, 0, 1, 32'h00FF0000, 1'b0, 1'b0);
        check("t_post_rst_rdata", r_rdata, 32'hFFFFFFFF);

        repeat (2) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
